// File: rtl/clock_time_ctrl_pkg.sv
// Shared definitions for the clock timekeeping sequencer: mode encodings,
// field moduli/maxima and the 24 h -> 12 h display mapping.
package clock_time_ctrl_pkg;

   localparam int FIELD_W  = 6;
   localparam int HOUR12_W = 4;

   localparam int HOURS_PER_DAY_DEF = 24;
   localparam int MIN_PER_HOUR_DEF  = 60;
   localparam int SEC_PER_MIN_DEF   = 60;

   localparam int HOUR_MAX = HOURS_PER_DAY_DEF - 1;
   localparam int MIN_MAX  = MIN_PER_HOUR_DEF - 1;
   localparam int SEC_MAX  = SEC_PER_MIN_DEF - 1;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'd0,
      MODE_SET_HR  = 2'd1,
      MODE_SET_MIN = 2'd2,
      MODE_SET_SEC = 2'd3
   } mode_t;

   // 0 -> 12, 1..12 unchanged, 13..23 -> hour-12
   function automatic logic [HOUR12_W-1:0] to_hour12(input logic [FIELD_W-1:0] h);
      logic [FIELD_W-1:0] tmp;
      tmp = h - FIELD_W'(12);
      if (h == '0)
         return HOUR12_W'(12);
      else if (h <= FIELD_W'(12))
         return h[HOUR12_W-1:0];
      else
         return tmp[HOUR12_W-1:0];
   endfunction

endpackage

// File: rtl/clock_time_ctrl_mod_counter.sv
// Modulo-MOD up counter used for the second, minute and hour fields.
//   clk, reset : clock, async active-low reset (value -> 0)
//   clr        : synchronous clear, has priority over inc
//   inc        : advance by one, wrapping to 0 after MOD-1
//   value      : registered count
//   wrap       : count is at (or beyond) its terminal value, i.e. the next
//                inc wraps; the controller gates it with its own inc
module mod_counter #(
   parameter int WIDTH = 6,
   parameter int MOD   = 60
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] value,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

   // out-of-range values behave as the maximum so they wrap to 0 next inc
   assign wrap = (value >= MAXV);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         value <= '0;
      else if (clr)
         value <= '0;
      else if (inc)
         value <= wrap ? '0 : value + WIDTH'(1);
   end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping sequencer: owns hour/minute/second, steps them on tick_1hz in
// RUN, and walks a button-driven SET flow (hour, minute, seconds-clear).
//   clk, reset : clock, async active-low reset
//   tick_1hz   : one-clk pulse per second
//   btn_mode   : advance mode (wins over btn_up in the same cycle)
//   btn_up     : increment selected field / clear seconds
//   hour/minute/second : registered time, 24 h
//   hour12     : registered 12 h display hour (1..12)
//   mode       : current mode (mode_t encoding)
//   blink      : field-blink enable, 0 in RUN
//   day_wrap   : one-clk pulse on 23:59:59 -> 00:00:00 in RUN
//
// state        | meaning
// MODE_RUN     | time advances on tick_1hz, btn_up ignored
// MODE_SET_HR  | time halted, btn_up increments hour (no carry)
// MODE_SET_MIN | time halted, btn_up increments minute (no carry)
// MODE_SET_SEC | time halted, btn_up clears second
module clock_time_ctrl
   import clock_time_ctrl_pkg::*;
#(
   parameter int HOURS_PER_DAY = HOURS_PER_DAY_DEF,
   parameter int MIN_PER_HOUR  = MIN_PER_HOUR_DEF,
   parameter int SEC_PER_MIN   = SEC_PER_MIN_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick_1hz,
   input  logic                btn_mode,
   input  logic                btn_up,
   output logic [FIELD_W-1:0]  hour,
   output logic [FIELD_W-1:0]  minute,
   output logic [FIELD_W-1:0]  second,
   output logic [HOUR12_W-1:0] hour12,
   output logic [1:0]          mode,
   output logic                blink,
   output logic                day_wrap
);

   mode_t state, state_nxt;
   logic  sec_inc, sec_clr, min_inc, hour_inc;
   logic  sec_wrap, min_wrap, hour_wrap;
   logic  blink_nxt;
   logic  day_wrap_nxt;
   logic [FIELD_W-1:0] hour_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= MODE_RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      sec_inc      = 1'b0;
      sec_clr      = 1'b0;
      min_inc      = 1'b0;
      hour_inc     = 1'b0;
      day_wrap_nxt = 1'b0;
      case (state)
         MODE_RUN: begin
            // a mode press does not swallow a coincident tick
            sec_inc      = tick_1hz;
            min_inc      = tick_1hz && sec_wrap;
            hour_inc     = tick_1hz && sec_wrap && min_wrap;
            day_wrap_nxt = tick_1hz && sec_wrap && min_wrap && hour_wrap;
            if (btn_mode)
               state_nxt = MODE_SET_HR;
         end
         MODE_SET_HR: begin
            if (btn_mode)
               state_nxt = MODE_SET_MIN;
            else
               hour_inc = btn_up;
         end
         MODE_SET_MIN: begin
            if (btn_mode)
               state_nxt = MODE_SET_SEC;
            else
               min_inc = btn_up;
         end
         MODE_SET_SEC: begin
            if (btn_mode)
               state_nxt = MODE_RUN;
            else
               sec_clr = btn_up;
         end
         default: state_nxt = MODE_RUN;
      endcase

      if (state_nxt == MODE_RUN)
         blink_nxt = 1'b0;
      else if (state_nxt != state)
         blink_nxt = 1'b1;
      else if (tick_1hz)
         blink_nxt = ~blink;
      else
         blink_nxt = blink;

      // mirrors the hour counter's update so hour12 lands in the same cycle
      if (hour_inc)
         hour_nxt = hour_wrap ? '0 : hour + FIELD_W'(1);
      else
         hour_nxt = hour;
   end

   mod_counter #(.WIDTH(FIELD_W), .MOD(SEC_PER_MIN)) u_sec (
      .clk   (clk),
      .reset (reset),
      .clr   (sec_clr),
      .inc   (sec_inc),
      .value (second),
      .wrap  (sec_wrap)
   );

   mod_counter #(.WIDTH(FIELD_W), .MOD(MIN_PER_HOUR)) u_min (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (min_inc),
      .value (minute),
      .wrap  (min_wrap)
   );

   mod_counter #(.WIDTH(FIELD_W), .MOD(HOURS_PER_DAY)) u_hour (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (hour_inc),
      .value (hour),
      .wrap  (hour_wrap)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink    <= 1'b0;
         day_wrap <= 1'b0;
         hour12   <= HOUR12_W'(12);
      end else begin
         blink    <= blink_nxt;
         day_wrap <= day_wrap_nxt;
         hour12   <= to_hour12(hour_nxt);
      end
   end

   assign mode = state;

endmodule

// File: tb/tb_clock_time_ctrl.sv
module tb_clock_time_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic [5:0] hour, minute, second;
   logic [3:0] hour12;
   logic [1:0] mode;
   logic       blink, day_wrap;

   int total = 0;
   int bad   = 0;

   // reference model state: plain integers
   int m_h, m_m, m_s, m_mode;
   bit m_blink, m_dw;

   always #5 clk = ~clk;

   clock_time_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .tick_1hz (tick_1hz),
      .btn_mode (btn_mode),
      .btn_up   (btn_up),
      .hour     (hour),
      .minute   (minute),
      .second   (second),
      .hour12   (hour12),
      .mode     (mode),
      .blink    (blink),
      .day_wrap (day_wrap)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0; m_dw = 0;
   endtask

   task automatic model_step(input bit t, input bit md, input bit up);
      int secs;
      m_dw = 0;
      if (m_mode == 0) begin
         if (t) begin
            secs = m_h * 3600 + m_m * 60 + m_s + 1;
            if (secs == 24 * 3600) begin
               secs = 0;
               m_dw = 1;
            end
            m_h = secs / 3600;
            m_m = (secs / 60) % 60;
            m_s = secs % 60;
         end
         if (md) m_mode = 1;
      end else if (md) begin
         m_mode = (m_mode + 1) % 4;
      end else if (up) begin
         case (m_mode)
            1: m_h = (m_h + 1) % 24;
            2: m_m = (m_m + 1) % 60;
            default: m_s = 0;
         endcase
      end
      if (m_mode == 0)  m_blink = 0;
      else if (md)      m_blink = 1;
      else if (t)       m_blink = !m_blink;
   endtask

   task automatic check_all(input string tag);
      int h12;
      h12 = (m_h % 12 == 0) ? 12 : m_h % 12;
      chk({tag, ".hour"},     hour,     m_h);
      chk({tag, ".minute"},   minute,   m_m);
      chk({tag, ".second"},   second,   m_s);
      chk({tag, ".hour12"},   hour12,   h12);
      chk({tag, ".mode"},     mode,     m_mode);
      chk({tag, ".blink"},    blink,    int'(m_blink));
      chk({tag, ".day_wrap"}, day_wrap, int'(m_dw));
   endtask

   task automatic step(input string tag, input bit t, input bit md, input bit up);
      @(negedge clk);
      tick_1hz = t; btn_mode = md; btn_up = up;
      @(posedge clk);
      model_step(t, md, up);
      #1;
      check_all(tag);
      tick_1hz = 0; btn_mode = 0; btn_up = 0;
   endtask

   task automatic repeat_step(input string tag, input int n, input bit t, input bit md, input bit up);
      for (int i = 0; i < n; i++) step(tag, t, md, up);
   endtask

   initial begin
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      reset = 1'b1;

      // 1: five ticks in RUN
      repeat_step("t1", 5, 1, 0, 0);
      chk("t1.sec5", second, 5);
      chk("t1.h12", hour12, 12);

      // 2: set 23:59:00, run 59 ticks to 23:59:59, then roll over
      step("t2.enter", 0, 1, 0);
      repeat_step("t2.hr", 23, 0, 0, 1);
      step("t2.tomin", 0, 1, 0);
      repeat_step("t2.min", 59, 0, 0, 1);
      step("t2.tosec", 0, 1, 0);
      step("t2.clr", 0, 0, 1);
      step("t2.torun", 0, 1, 0);
      repeat_step("t2.run", 59, 1, 0, 0);
      chk("t2.pre_h", hour, 23);
      chk("t2.pre_s", second, 59);
      step("t2.wrap", 1, 0, 0);
      chk("t2.dw_hi", day_wrap, 1);
      step("t2.after", 0, 0, 0);
      chk("t2.dw_lo", day_wrap, 0);

      // 3: hour setting and manual wrap
      step("t3.enter", 0, 1, 0);
      repeat_step("t3.up13", 13, 0, 0, 1);
      chk("t3.h13", hour, 13);
      chk("t3.h12_1", hour12, 1);
      repeat_step("t3.up11", 11, 0, 0, 1);
      chk("t3.h0", hour, 0);

      // 4: minute wrap without carry; ticks halted, blink toggles
      step("t4.tomin", 0, 1, 0);
      repeat_step("t4.up", 59, 0, 0, 1);
      chk("t4.m59", minute, 59);
      step("t4.wrap", 0, 0, 1);
      chk("t4.m0", minute, 0);
      repeat_step("t4.tick", 3, 1, 0, 0);

      // 5: mode and up together in SET_HR
      step("t5.sec", 0, 1, 0);
      step("t5.run", 0, 1, 0);
      step("t5.hr_tick", 1, 1, 0);   // tick and mode together in RUN
      step("t5.both", 0, 1, 1);
      chk("t5.mode", mode, 2);

      // 6: seconds clear then resume, then async reset mid SET_MIN
      step("t6.sec", 0, 1, 0);
      step("t6.run", 0, 1, 0);
      while (m_s != 42) step("t6.tick", 1, 0, 0);
      step("t6.hr", 0, 1, 0);
      step("t6.min", 0, 1, 0);
      step("t6.sec2", 0, 1, 0);
      chk("t6.s42", second, 42);
      step("t6.clr", 0, 0, 1);
      step("t6.run2", 0, 1, 0);
      step("t6.tick1", 1, 0, 0);
      chk("t6.s1", second, 1);
      step("t6.hr3", 0, 1, 0);
      step("t6.min3", 0, 1, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check_all("t6.rst");
      @(negedge clk);
      reset = 1'b1;

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step("rand",
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 2) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
